ofifo: RTL and testbench
========================

Name: ofifo

Overview:
- Output FIFO directly downstream of mac_array; captures each column's south partial sum (out_s) whenever that column's valid bit is asserted.
- Each column owns an independent FIFO, because systolic skew makes columns produce results on different cycles.
- Presents a full, re-aligned row of col psums to the accumulation/SFU stage once every column holds at least one entry.

Parameters:
- col, 8, number of columns; must equal the mac_array col.
- psum_bw, 16, bits per partial sum.
- depth, 16, entries per column FIFO; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in  in  psum_bw*col  psums from mac_array out_s; column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
- wr  in  col  per-column write strobe, driven by mac_array valid.
- rd  in  1  pops one entry from every column at once; honoured only while o_valid=1.
- out  out  psum_bw*col  head entry of each column, same packing as in; forced to 0 while o_valid=0.
- o_valid  out  1  every column is non-empty.
- o_full  out  1  at least one column holds depth entries.

Behaviour:
- Reset (synchronous, active-high): all write/read pointers and counts go to 0. On the next cycle o_valid=0, o_full=0, out=0. RAM contents are not cleared. Reset overrides any rd or wr in the same cycle, including mid-operation.
- Per-column state:
  - wptr and rptr, each log2(depth) bits, wrap modulo depth.
  - cnt, log2(depth)+1 bits.
- Pop: pop = rd & o_valid. When pop=1, every column advances rptr by 1. rd while o_valid=0 is ignored and changes no state.
- Push for column i: push_i = wr[i] & (cnt_i < depth | pop).
  - On push, in[i] is stored at wptr_i and wptr_i advances.
  - wr[i] while column i is full and no pop occurs: the write is dropped and no state changes.
- Count update: cnt_i = cnt_i + push_i - pop. A simultaneous push and pop leaves the count unchanged, and ordering is preserved.
- Read timing: first-word-fall-through. out is combinational from the head entries.
  - A write at edge N is visible at out after edge N if that column was previously empty.
  - Write-to-o_valid latency is 1 cycle, counted from the last column's write.
- Flags: o_valid = AND of (cnt_i != 0) over all columns. o_full = OR of (cnt_i == depth).
- Width: psums are stored and output unmodified; there is no sign extension or arithmetic.

Optional Feature:
- Macro: OFIFO_OVERFLOW_FLAG_EN.
- When defined:
  - Extra port o_overflow, output, col bits.
  - Bit i is set sticky when wr[i] is asserted, column i is full, and no pop occurs that cycle.
  - Bits clear only on reset and read 0 after reset.
- When not defined: the port is absent and dropped writes are silent. All other behaviour is identical.

Decomposition:
- Shared package ofifo_pkg holds:
  - default constants OFIFO_DEPTH=16 and PSUM_BW=16;
  - localparam functions for pointer width (clog2(depth)) and count width (clog2(depth)+1).
- One natural sub-module: ofifo_col, a single-column psum_bw x depth FWFT FIFO with push, pop, head, cnt, empty and full.
- ofifo instantiates col copies of ofifo_col via generate and adds the cross-column AND/OR flag logic and output gating.

Test Plan:
1. Reset asserted for 2 cycles, then released -> o_valid=0, o_full=0, out=0; o_overflow=0 if enabled.
2. One cycle of wr=8'hFF with in={8{16'h0032}}, then idle -> next cycle o_valid=1 and out={8{16'h0032}}. After one rd cycle -> o_valid=0 and out=0.
3. Skewed writes: wr=8'h01, 8'h03, 8'h07 … 8'hFF on cycles 0–7, with column i data = 16'h0100+i -> o_valid stays 0 through cycle 7 and goes to 1 after cycle 7. out column i = 16'h0100+i; columns 0–6 hold extra entries afterwards.
4. Column 0 only, with other columns pre-loaded with 1 entry: write 16 values 0..15 -> o_full=1. A 17th write of 16'hDEAD is dropped (o_overflow[0]=1 if enabled). Popping 16 times returns 0..15 in order.
5. Column 0 full, rd=1 and wr=8'hFF in the same cycle -> o_full stays 1, no overflow is flagged, and the new entry is read last.
6. 40 streaming cycles of wr=8'hFF with data k (k=0..39), with rd=1 from cycle 1 onwards -> out sequence is 0..39 across pointer wrap. Then assert reset with 5 entries resident -> o_valid=0 on the following cycle.

Source files
------------

// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared constants and width helpers for the output FIFO.
//   OFIFO_DEPTH / PSUM_BW / OFIFO_COL : default sizing
//   ptr_width(depth) : read/write pointer width, clog2(depth)
//   cnt_width(depth) : occupancy count width, clog2(depth)+1 (must hold depth itself)
package ofifo_pkg;

    localparam int OFIFO_DEPTH = 16;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_COL   = 8;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_if.sv
// ofifo_if: bus between mac_array side / consumer side and the output FIFO.
//   in      : packed column psums, column i at [PSUM_BW*(i+1)-1 : PSUM_BW*i]
//   wr      : per-column write strobe (mac_array valid)
//   rd      : pop one entry from every column (honoured only while o_valid)
//   out     : head entry of each column, zero while o_valid=0
//   o_valid : every column non-empty
//   o_full  : at least one column full
//   o_overflow (only with OFIFO_OVERFLOW_FLAG_EN) : sticky per-column drop flag
// Modports: slave = the FIFO, master = the driver/consumer.
interface ofifo_if #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16
);
    logic [PSUM_BW*COL-1:0] in;
    logic [COL-1:0]         wr;
    logic                   rd;
    logic [PSUM_BW*COL-1:0] out;
    logic                   o_valid;
    logic                   o_full;
`ifdef OFIFO_OVERFLOW_FLAG_EN
    logic [COL-1:0]         o_overflow;

    modport slave  (input in, wr, rd, output out, o_valid, o_full, o_overflow);
    modport master (output in, wr, rd, input out, o_valid, o_full, o_overflow);
`else
    modport slave  (input in, wr, rd, output out, o_valid, o_full);
    modport master (output in, wr, rd, input out, o_valid, o_full);
`endif
endinterface

// File: rtl/ofifo_col.sv
// ofifo_col: single-column first-word-fall-through FIFO, psum_bw x depth.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   push, pop  : caller guarantees push only when not full (or with pop),
//                pop only when not empty
//   din        : data written at the write pointer on push
//   head       : combinational read of the entry at the read pointer
//   cnt        : occupancy, 0..depth
//   empty/full : cnt == 0 / cnt == depth
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [psum_bw-1:0]       din,
    output logic [psum_bw-1:0]       head,
    output logic [$clog2(depth):0]   cnt,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = ptr_width(depth);
    localparam int CNT_W = cnt_width(depth);

    logic [psum_bw-1:0] mem_reg [depth];
    logic [PTR_W-1:0]   wptr_reg;
    logic [PTR_W-1:0]   rptr_reg;
    logic [CNT_W-1:0]   cnt_reg;

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            if (push) wptr_reg <= wptr_reg + 1'b1;
            if (pop)  rptr_reg <= rptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Storage is deliberately not reset. A push into a full column only
    // happens together with a pop, so it overwrites the slot being popped.
    always_ff @(posedge clk) begin
        if (push) mem_reg[wptr_reg] <= din;
    end

    // Fall-through head: a write into an empty column is visible right after its edge.
    assign head  = mem_reg[rptr_reg];
    assign cnt   = cnt_reg;
    assign empty = (cnt_reg == '0);
    assign full  = (cnt_reg == CNT_W'(depth));

endmodule

// File: rtl/ofifo.sv
// ofifo: per-column output FIFO behind mac_array. Each column buffers its own
// skewed psum stream; a re-aligned row is presented once all columns hold data.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ofifo_if.slave (in, wr, rd, out, o_valid, o_full[, o_overflow])
// Optional macro OFIFO_OVERFLOW_FLAG_EN adds sticky per-column o_overflow,
// set when a write is dropped (column full, no pop that cycle).
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = OFIFO_COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic  clk,
    input  logic  reset,
    ofifo_if.slave bus
);
    localparam int CNT_W = cnt_width(depth);

    logic [col-1:0]   push;
    logic [col-1:0]   col_empty;
    logic [col-1:0]   col_full;
    logic [col-1:0]   col_at_depth;
    logic [CNT_W-1:0] col_cnt  [col];
    logic [psum_bw-1:0] col_head [col];
    logic             pop;
    logic             valid;

    assign valid = ~|col_empty;
    // rd while no full row is available is ignored entirely.
    assign pop   = bus.rd & valid;

    genvar gi;
    generate
        for (gi = 0; gi < col; gi++) begin : g_col
            // A full column still accepts a write when the same cycle pops.
            assign push[gi] = bus.wr[gi] & (~col_full[gi] | pop);

            ofifo_col #(
                .psum_bw (psum_bw),
                .depth   (depth)
            ) u_col (
                .clk   (clk),
                .reset (reset),
                .push  (push[gi]),
                .pop   (pop),
                .din   (bus.in[gi*psum_bw +: psum_bw]),
                .head  (col_head[gi]),
                .cnt   (col_cnt[gi]),
                .empty (col_empty[gi]),
                .full  (col_full[gi])
            );

            assign col_at_depth[gi] = (col_cnt[gi] == CNT_W'(depth));
            assign bus.out[gi*psum_bw +: psum_bw] = valid ? col_head[gi] : '0;
        end
    endgenerate

    assign bus.o_valid = valid;
    assign bus.o_full  = |col_at_depth;

`ifdef OFIFO_OVERFLOW_FLAG_EN
    logic [col-1:0] overflow_reg;
    logic [col-1:0] overflow_set;

    assign overflow_set = bus.wr & col_full & {col{~pop}};

    always_ff @(posedge clk) begin
        if (reset) overflow_reg <= '0;
        else       overflow_reg <= overflow_reg | overflow_set;
    end

    assign bus.o_overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_ofifo.sv
module tb_ofifo;
    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 16;

    logic clk;
    logic reset;

    ofifo_if #(.COL(COL), .PSUM_BW(BW)) bus ();

    ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each column is an ordered list of psums with a length.
    logic [BW-1:0]  mdat [COL][DEPTH];
    int             mcnt [COL];
    logic [COL-1:0] movf;
    bit             chk_en;
    int             tests;
    int             errors;
    int             pops;

    task automatic chk(input string nm, input logic [BW*COL-1:0] act, input logic [BW*COL-1:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Applied at each rising edge with the inputs that were presented.
    task automatic model_update(input logic r, input logic [COL-1:0] w,
                                input logic [BW*COL-1:0] d, input logic rdi);
        bit all_ne;
        bit do_pop;
        all_ne = 1'b1;
        for (int i = 0; i < COL; i++) if (mcnt[i] == 0) all_ne = 1'b0;
        do_pop = rdi && all_ne;
        if (r) begin
            for (int i = 0; i < COL; i++) mcnt[i] = 0;
            movf   = '0;
            chk_en = 1'b1;
            return;
        end
        for (int i = 0; i < COL; i++) begin
            if (w[i] && mcnt[i] == DEPTH && !do_pop) movf[i] = 1'b1;
            if (do_pop) begin
                for (int j = 0; j < DEPTH-1; j++) mdat[i][j] = mdat[i][j+1];
                mcnt[i]--;
            end
            if (w[i] && mcnt[i] < DEPTH) begin
                mdat[i][mcnt[i]] = d[BW*i +: BW];
                mcnt[i]++;
            end
        end
    endtask

    // Drive one cycle of stimulus and record the expected effect.
    task automatic step(input logic r, input logic [COL-1:0] w,
                        input logic [BW*COL-1:0] d, input logic rdi);
        reset  = r;
        bus.wr = w;
        bus.in = d;
        bus.rd = rdi;
        @(posedge clk);
        model_update(r, w, d, rdi);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: compares the presented DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            logic               exp_valid;
            logic               exp_full;
            logic [BW*COL-1:0]  exp_out;
            exp_valid = 1'b1;
            exp_full  = 1'b0;
            exp_out   = '0;
            for (int i = 0; i < COL; i++) begin
                if (mcnt[i] == 0)     exp_valid = 1'b0;
                if (mcnt[i] == DEPTH) exp_full  = 1'b1;
            end
            if (exp_valid)
                for (int i = 0; i < COL; i++) exp_out[BW*i +: BW] = mdat[i][0];
            chk("o_valid", {{(BW*COL-1){1'b0}}, bus.o_valid}, {{(BW*COL-1){1'b0}}, exp_valid});
            chk("o_full",  {{(BW*COL-1){1'b0}}, bus.o_full},  {{(BW*COL-1){1'b0}}, exp_full});
            chk("out", bus.out, exp_out);
`ifdef OFIFO_OVERFLOW_FLAG_EN
            chk("o_overflow", {{(BW*COL-COL){1'b0}}, bus.o_overflow}, {{(BW*COL-COL){1'b0}}, movf});
`endif
            if (bus.rd && bus.o_valid && !reset) begin
                pops++;
                $display("[TB] pop %0d row %h", pops, bus.out);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [BW*COL-1:0] d;
        tests  = 0;
        errors = 0;
        pops   = 0;
        chk_en = 1'b0;
        movf   = '0;
        for (int i = 0; i < COL; i++) mcnt[i] = 0;
        reset  = 1'b1;
        bus.wr = '0;
        bus.in = '0;
        bus.rd = 1'b0;

        // 1. reset for two cycles
        step(1'b1, '0, '0, 1'b0);
        step(1'b1, '0, '0, 1'b0);
        idle();

        // 2. single full-row write, visible next cycle, then one pop
        step(1'b0, 8'hFF, {8{16'h0032}}, 1'b0);
        idle();
        step(1'b0, '0, '0, 1'b1);
        idle();

        // 3. skewed writes, column i data 0x0100+i
        for (int i = 0; i < COL; i++) d[BW*i +: BW] = 16'h0100 + 16'(i);
        for (int c = 0; c < COL; c++) step(1'b0, 8'((1 << (c+1)) - 1), d, 1'b0);
        idle();
        step(1'b0, '0, '0, 1'b1);
        idle();
        step(1'b1, '0, '0, 1'b0);

        // 4. column 0 fill to depth, dropped 17th write, ordered drain
        step(1'b0, 8'hFE, {8{16'h00AA}}, 1'b0);
        for (int k = 0; k < DEPTH; k++) step(1'b0, 8'h01, {112'h0, 16'(k)}, 1'b0);
        step(1'b0, 8'h01, {112'h0, 16'hDEAD}, 1'b0);
        for (int k = 0; k < DEPTH; k++) step(1'b0, 8'hFE, {8{16'h00AA}}, 1'b1);
        step(1'b1, '0, '0, 1'b0);

        // 5. full column with simultaneous pop and write
        step(1'b0, 8'hFE, {8{16'h00BB}}, 1'b0);
        for (int k = 0; k < DEPTH; k++) step(1'b0, 8'h01, {112'h0, 16'(k + 16'h20)}, 1'b0);
        step(1'b0, 8'hFF, {8{16'h0077}}, 1'b1);
        for (int k = 0; k < DEPTH; k++) step(1'b0, 8'hFE, {8{16'h00CC}}, 1'b1);
        step(1'b1, '0, '0, 1'b0);

        // 6. streaming across pointer wrap, then reset with entries resident
        for (int k = 0; k < 40; k++) step(1'b0, 8'hFF, {8{16'(k)}}, k >= 1);
        for (int k = 0; k < 4; k++) step(1'b0, 8'hFF, {8{16'(100 + k)}}, 1'b0);
        step(1'b1, '0, '0, 1'b0);
        idle();

        // Random traffic, write-heavy first half to reach full, then read-heavy
        for (int k = 0; k < 800; k++) begin
            logic [COL-1:0] w;
            logic           r;
            logic           rdi;
            d   = {$urandom, $urandom, $urandom, $urandom};
            w   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            rdi = (k < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 199) == 0);
            step(r, w, d, rdi);
        end
        idle();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
